// File: rtl/countdown_timer_array_pkg.sv
// Shared definitions for the countdown timer array: channel state encoding
// and the prescaler width helper.
package countdown_timer_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } ch_state_e;

  localparam int N_CH_DEF     = 4;
  localparam int WIDTH_DEF    = 10;
  localparam int PRESCALE_DEF = 50;

  // A prescale of 1 still needs a one-bit counter to keep the port widths legal.
  function automatic int presc_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/countdown_channel.sv
// One countdown channel: start value latch, down-counter, hold/abort handling
// and registered busy/done.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | stopped, count is 0 (or just expired / aborted)
// ST_RUN  | counting down one step per tick
// ST_HOLD | count frozen while hold is high; ticks are discarded
module countdown_channel
  import countdown_timer_array_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             tick,
  input  logic             begin_count,
  input  logic [WIDTH-1:0] start_val,
  input  logic             auto_reload,
  input  logic             hold,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
      busy_d  = 1'b0;
    end else if (begin_count) begin
      reload_d = start_val;
      count_d  = start_val;
      // A zero start value expires immediately instead of entering RUN.
      if (start_val == '0) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hold) begin
            state_d = ST_HOLD;
          end else if (tick && (count_q != '0)) begin
            if (count_q == ONE) begin
              done_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              count_d = count_q - ONE;
            end
          end
        end
        ST_HOLD: begin
          if (!hold) state_d = ST_RUN;
        end
        ST_IDLE: begin
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: rtl/countdown_timer_array.sv
// Array of independent countdown channels driven by one free-running shared
// prescaler tick.
module countdown_timer_array
  import countdown_timer_array_pkg::*;
#(
  parameter int N_CH     = N_CH_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [N_CH-1:0]       beginCount,
  input  logic [N_CH*WIDTH-1:0] counterSeconds,
  input  logic [N_CH-1:0]       autoReload,
  input  logic [N_CH-1:0]       hold,
  input  logic [N_CH-1:0]       abort,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done
);

  localparam int              PW      = presc_width(PRESCALE);
  localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // The prescaler is never restarted by a load, so all channels stay on one tick grid.
  always_comb begin
    tick    = (presc_q == PS_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) presc_q <= '0;
    else        presc_q <= presc_d;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    countdown_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .Clock      (Clock),
      .Reset      (Reset),
      .tick       (tick),
      .begin_count(beginCount[i]),
      .start_val  (counterSeconds[i*WIDTH +: WIDTH]),
      .auto_reload(autoReload[i]),
      .hold       (hold[i]),
      .abort      (abort[i]),
      .count      (count[i*WIDTH +: WIDTH]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule
